// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Round-robin scheduler sharing one 3-bit-to-7-segment decoder among DIGITS
// digits. Every digit slot is PRESCALE cycles long: BLANK dark cycles (anti-
// ghosting), then a lit interval. New code sets are double-buffered and only
// take effect on slot boundaries or when scanning starts.
// All outputs come straight from flops. They are loaded from the next-state
// values, so they line up cycle-for-cycle with the internal state.
module display_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [3*DIGITS-1:0]   codes_in,
  output logic [2:0]            user_sel,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  load_ack,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  // Select the 3-bit code of digit idx from a packed code set.
  function automatic logic [2:0] pick_code(input logic [3*DIGITS-1:0] codes,
                                           input logic [IDX_W-1:0]    idx);
    logic [2:0] code;
    code = 3'd0;
    for (int k = 0; k < DIGITS; k++) begin
      code = (idx == IDX_W'(k)) ? codes[3*k +: 3] : code;
    end
    return code;
  endfunction

  // One-hot enable for digit idx.
  function automatic logic [DIGITS-1:0] one_hot(input logic [IDX_W-1:0] idx);
    logic [DIGITS-1:0] oh;
    oh = '0;
    for (int k = 0; k < DIGITS; k++) begin
      oh[k] = (idx == IDX_W'(k));
    end
    return oh;
  endfunction

  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]      idx_r, idx_nxt_s;
  logic [3*DIGITS-1:0]   active_r, active_nxt_s;
  logic [3*DIGITS-1:0]   pending_r, pending_nxt_s;
  logic                  pend_valid_r, pend_valid_nxt_s;
  logic                  apply_point_s;
  logic                  wrap_s;
  logic                  ack_nxt_s;
  logic [2:0]            user_sel_nxt_s;
  logic [DIGITS-1:0]     digit_en_nxt_s;

  // Next-state logic: slot counter, digit index and apply points.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    idx_nxt_s     = idx_r;
    apply_point_s = 1'b0;
    wrap_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        idx_nxt_s = {IDX_W{1'b0}};
        if (enable) begin
          state_nxt_s   = S_BLANK;
          apply_point_s = 1'b1;
        end else begin
          state_nxt_s   = S_IDLE;
        end
      end
      S_BLANK: begin
        if (!enable) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
          idx_nxt_s   = {IDX_W{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
          state_nxt_s = (cnt_r == CNT_BLANK_LAST) ? S_SHOW : S_BLANK;
        end
      end
      S_SHOW: begin
        if (!enable) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
          idx_nxt_s   = {IDX_W{1'b0}};
        end else if (cnt_r == CNT_SLOT_LAST) begin
          // Slot boundary: next digit starts dark, new codes may land here.
          state_nxt_s   = S_BLANK;
          cnt_nxt_s     = {CNT_W{1'b0}};
          idx_nxt_s     = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
          apply_point_s = 1'b1;
          wrap_s        = (idx_r == IDX_LAST);
        end else begin
          state_nxt_s = S_SHOW;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Code-set double buffer: a load landing on an apply point bypasses the
  // pending register; otherwise it is parked there until the next apply point.
  always_comb begin
    active_nxt_s     = active_r;
    pending_nxt_s    = pending_r;
    pend_valid_nxt_s = pend_valid_r;
    ack_nxt_s        = 1'b0;
    if (apply_point_s) begin
      if (load) begin
        active_nxt_s     = codes_in;
        pend_valid_nxt_s = 1'b0;
        ack_nxt_s        = 1'b1;
      end else if (pend_valid_r) begin
        active_nxt_s     = pending_r;
        pend_valid_nxt_s = 1'b0;
        ack_nxt_s        = 1'b1;
      end else begin
        ack_nxt_s        = 1'b0;
      end
    end else if (load) begin
      pending_nxt_s    = codes_in;
      pend_valid_nxt_s = 1'b1;
    end else begin
      pend_valid_nxt_s = pend_valid_r;
    end
  end

  // Output values derived from the state the scan is about to enter.
  always_comb begin
    user_sel_nxt_s = 3'd0;
    digit_en_nxt_s = {DIGITS{1'b0}};
    case (state_nxt_s)
      S_BLANK: begin
        user_sel_nxt_s = pick_code(active_nxt_s, idx_nxt_s);
      end
      S_SHOW: begin
        user_sel_nxt_s = pick_code(active_nxt_s, idx_nxt_s);
        digit_en_nxt_s = one_hot(idx_nxt_s);
      end
      default: begin
        user_sel_nxt_s = 3'd0;
        digit_en_nxt_s = {DIGITS{1'b0}};
      end
    endcase
  end

  // Scan state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Active and pending code-set registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r     <= {(3*DIGITS){1'b0}};
      pending_r    <= {(3*DIGITS){1'b0}};
      pend_valid_r <= 1'b0;
    end else begin
      active_r     <= active_nxt_s;
      pending_r    <= pending_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      user_sel   <= 3'd0;
      digit_en   <= {DIGITS{1'b0}};
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      user_sel   <= user_sel_nxt_s;
      digit_en   <= digit_en_nxt_s;
      load_ack   <= ack_nxt_s;
      frame_done <= wrap_s;
    end
  end

endmodule
